// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with configurable width,
// parity and stop bits, delivering frames through a valid/ready register.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);
  localparam logic PAR_REF = 1'(PARITY == 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t               state, state_n;
  logic [1:0]           sync_q;
  logic                 rxd_s;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par, par_n;
  logic                 perr, perr_n;
  logic                 ferr, ferr_n;
  logic                 armed, armed_n;
  logic                 load;

  assign rxd_s   = sync_q[1];
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= 2'b11;
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
      armed  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rxd};
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      shreg  <= shreg_n;
      par    <= par_n;
      perr   <= perr_n;
      ferr   <= ferr_n;
      armed  <= armed_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shreg_n = shreg;
    par_n   = par;
    perr_n  = perr;
    ferr_n  = ferr;
    armed_n = armed;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (armed && !rxd_s) begin
          state_n = START;
          armed_n = 1'b0;
          idx_n   = '0;
          par_n   = 1'b0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end else if (rxd_s) begin
          armed_n = 1'b1;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          if (!rxd_s) begin
            state_n = DATA;
          end else begin
            // glitch: line already high again
            state_n = IDLE;
            armed_n = 1'b1;
          end
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          shreg_n = {rxd_s, shreg[DATA_BITS-1:1]};
          par_n   = par ^ rxd_s;
          if (idx == LAST_D) begin
            idx_n   = '0;
            state_n = (PARITY != 0) ? PAR : STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      PAR: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          perr_n  = (par ^ rxd_s) != PAR_REF;
          state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          if (!rxd_s) ferr_n = 1'b1;
          if (idx == LAST_S) begin
            load    = 1'b1;
            idx_n   = '0;
            state_n = IDLE;
            armed_n = rxd_s;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (load) begin
        if (rx_valid && !rx_ready) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_data       <= shreg;
          rx_valid      <= 1'b1;
          rx_parity_err <= perr;
          rx_frame_err  <= ferr_n;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receive engine: the next-generation replacement for the fixed-format `receiver` block. It oversamples the serial line `rxd` on the system clock and supports configurable data width, parity mode and stop-bit count. Each received frame is delivered through a valid/ready holding register, with parity, framing and overrun status. The block sits between the pad-side `rxd` input and the host/FIFO side of the UART controller.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per bit period; legal range ≥ 4. `HALF` = `CLKS_PER_BIT/2` (floor).
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `PARITY`, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: number of stop bits; 1 or 2.

Ports (clock and reset first):
- `clk`  in  1: single system clock, rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `rxd`  in  1: asynchronous serial input; idle high.
- `rx_ready`  in  1: consumer accepts the held frame when `rx_valid`=1.
- `rx_data`  out  DATA_BITS: received data, LSB first on the line.
- `rx_valid`  out  1: holding register full; level signal.
- `rx_parity_err`  out  1: parity mismatch for the held frame; 0 when `PARITY`=0.
- `rx_frame_err`  out  1: at least one stop bit was sampled low for the held frame.
- `rx_overrun`  out  1: one-cycle pulse when a completed frame is dropped.
- `rx_busy`  out  1: high in every state except IDLE.

## Operation
- **Synchroniser.** `rxd` passes through 2 flops to give `rxd_s`. Both flops reset to 1.
- **Start detection.**
  - In IDLE, the engine arms only after observing `rxd_s`=1.
  - While armed, `rxd_s`=0 starts a frame. That cycle is T0; the next state is START and the bit-timer `cnt` is cleared.
  - A line held low (break) does not retrigger until `rxd_s` has returned high.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - START: sample at `cnt`=HALF-1. If the sample is 0, go to DATA. If it is 1 (glitch), return to IDLE with no output and no flags.
  - DATA: sample every CLKS_PER_BIT cycles; shift in LSB first; bit index counts 0..DATA_BITS-1. After the last bit, go to PARITY if `PARITY`≠0, otherwise to STOP.
  - PARITY: one sample. Error = (XOR of data bits XOR parity bit) ≠ (`PARITY`==1 ? 1 : 0).
  - STOP: take `STOP_BITS` samples. Any 0 sets the frame error.
  - After the final stop sample, load the holding register and go directly to IDLE. IDLE re-arms immediately if `rxd_s`=1.
- **Errored frames** are still delivered; the flags qualify them. Both flags are registered together with `rx_data` and are meaningful only while `rx_valid`=1.
- **Holding register / handshake.**
  - A load sets `rx_valid`=1.
  - `rx_valid` & `rx_ready` in cycle N clears `rx_valid` at N+1.
  - A load while `rx_valid`=1 and `rx_ready`=0: the new frame is discarded, the old data and flags are kept, and `rx_overrun` pulses for 1 cycle.
  - Load and accept in the same cycle: the new frame is loaded, `rx_valid` stays 1, and there is no overrun.
- **Reset** (`rst`=0 at a rising edge), including mid-frame:
  - FSM goes to IDLE; counters clear.
  - `rx_data`=0, `rx_valid`=0, `rx_parity_err`=0, `rx_frame_err`=0, `rx_overrun`=0, `rx_busy`=0.
  - Synchroniser set to 1; any partial frame is discarded.

## Timing
- Input to detection: a low on `rxd` is observed in IDLE 2–3 cycles later (synchroniser plus the IDLE check).
- Sample instants relative to T0:
  - start bit: T0+HALF
  - data bit i: T0+HALF+(i+1)·CLKS_PER_BIT
  - parity bit: T0+HALF+(DATA_BITS+1)·CLKS_PER_BIT
  - stop bit k (k = 0, 1): following the parity bit, or the last data bit when `PARITY`=0, at successive CLKS_PER_BIT intervals.
- `rx_valid` rises the cycle after the last stop sample. With defaults (8N1, 16): last stop sample at T0+152, `rx_valid`=1 from T0+153.
- `rx_busy`=1 from T0+1 through the cycle of the last stop sample.
- Back-to-back frames with no idle gap are received without loss, given a timely `rx_ready`.

## Test plan
- **Reset values:** hold `rst`=0 for 3 cycles with `rxd` toggling -> all outputs 0 and `rx_busy`=0.
- **Single 8N1 frame (defaults):** send 0xA5, keep `rx_ready`=0 -> `rx_valid`=1 at T0+153 with `rx_data`=0xA5, both error flags 0. Assert `rx_ready` for 1 cycle -> `rx_valid`=0 next cycle.
- **Even parity and framing error:** with DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x35 with wrong parity and the second stop bit low -> `rx_data`=0x35, `rx_parity_err`=1, `rx_frame_err`=1.
- **Start glitch:** pull `rxd` low for 3 cycles with CLKS_PER_BIT=16 -> no `rx_valid`, FSM back in IDLE, and the next valid frame 0x3C is received correctly.
- **Overrun and accept collision:**
  - Send 0x11 then 0x22 back-to-back with `rx_ready`=0 -> `rx_data` stays 0x11 and `rx_overrun` pulses once.
  - Repeat with `rx_ready`=1 exactly on the load cycle of 0x22 -> `rx_data`=0x22, `rx_valid` stays 1, no overrun.
- **Reset mid-frame:** assert `rst`=0 at T0+60 of a frame, release, then send 0x5A -> only 0x5A is delivered, with no errors.
